// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; storage is not reset, only pointers and count.
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// FIFO-buffered UART transmitter, 8N1 LSB first at CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              bit_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign bit_done = (baud_cnt == BAUD_LAST);
  // Pop from IDLE, or at the very end of a stop bit so frames run back to back.
  assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));

  uart_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo_dout;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^fifo_dout;
`endif
    end else if (bit_done && (state == START || state == DATA)) begin
      shift <= shift >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_tx  <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= UART_IDLE_LEVEL;
          busy     <= 1'b0;
          baud_cnt <= '0;
          if (pop) begin
            uart_tx <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              uart_tx <= parity_bit;
              state   <= PARITY;
`else
              uart_tx <= UART_IDLE_LEVEL;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shift[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            baud_cnt <= '0;
            uart_tx  <= UART_IDLE_LEVEL;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              uart_tx <= UART_IDLE_LEVEL;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          uart_tx  <= UART_IDLE_LEVEL;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: frame-time reference model plus a line receiver.
// Honours UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx_fifo_ctrl;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             uart_tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  uart_tx_fifo_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of waiting bytes plus time-into-frame of the byte on the line.
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_active = 1'b0;
  bit         m_acc = 1'b0;
  int         m_t = 0;

  logic [7:0] rx_got[$];
  logic [7:0] rx_byte = 8'h00;
  bit         rx_active = 1'b0;
  int         rx_t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_line();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    if (m_active) void'(m_sent.pop_back());
    m_q.delete();
    m_active = 1'b0;
    m_acc    = 1'b0;
    m_t      = 0;
    rx_active = 1'b0;
  endtask

  // Applies one clock edge using the inputs as they stood just before it.
  task automatic model_edge();
    bit ending;
    bit do_pop;
    if (reset) begin
      model_reset();
      return;
    end
    ending = m_active && (m_t == FRAME - 1);
    do_pop = (m_q.size() > 0) && (!m_active || ending);
    m_acc  = tx_valid && (m_q.size() < DEPTH);
    if (m_active) m_t++;
    if (ending) m_active = 1'b0;
    if (do_pop) begin
      m_cur = m_q.pop_front();
      m_sent.push_back(m_cur);
      m_active = 1'b1;
      m_t = 0;
    end
    if (m_acc) m_q.push_back(tx_data);
  endtask

  task automatic check_outputs();
    chk("uart_tx", uart_tx, exp_line());
    chk("busy", busy, m_active);
    chk("fifo_count", fifo_count, m_q.size());
    chk("tx_ready", tx_ready, (m_q.size() != DEPTH));
  endtask

  // Independent receiver: mid-bit sampling of the DUT line after each falling start edge.
  task automatic rx_sample();
    int k;
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t = 0;
      end
    end else begin
      rx_t++;
      if (((rx_t - CPB/2) % CPB) == 0) begin
        k = (rx_t - CPB/2) / CPB;
        if (k >= 1 && k <= 8) rx_byte[k-1] = uart_tx;
        if (k == NBITS - 1) begin
          chk("stop_bit", uart_tx, 1);
          rx_got.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    rx_sample();
  endtask

  task automatic push_seq(input logic [7:0] bytes[$], input int max_cycles);
    int i = 0;
    int n = 0;
    while (i < bytes.size() && n < max_cycles) begin
      tx_valid = 1'b1;
      tx_data  = bytes[i];
      step();
      if (m_acc) i++;
      n++;
    end
    tx_valid = 1'b0;
    chk("push_timeout", i, bytes.size());
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((m_active || m_q.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", (m_active || m_q.size() > 0), 0);
    for (int j = 0; j < 3; j++) step();
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h77) b = 8'h78;
    return b;
  endfunction

  initial begin
    logic [7:0] bq[$];
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #3;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 1);
    step();
    step();
    reset = 1'b0;
    step();

    // Single frames
    bq = '{8'h55};
    push_seq(bq, 5);
    drain(100);
    bq = '{8'hA3};
    push_seq(bq, 5);
    drain(100);

    // Six bytes held back to back; the sixth waits for the first frame to end
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
    push_seq(bq, 10);
    chk("full_count", fifo_count, 4);
    chk("full_ready", tx_ready, 0);
    bq = '{8'h66};
    push_seq(bq, 2 * FRAME);
    drain(8 * FRAME);

    // Consecutive 0xFF / 0x00
    bq = '{8'hFF, 8'h00};
    push_seq(bq, 5);
    drain(4 * FRAME);

    // Reset mid-frame with two bytes queued
    bq = '{8'h12, 8'h34, 8'h56};
    push_seq(bq, 6);
    for (int n = 0; n < 40 && m_t < 15; n++) step();
    chk("mid_frame_t", m_t, 15);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_uart_tx", uart_tx, 1);
    chk("async_busy", busy, 0);
    chk("async_count", fifo_count, 0);
    chk("async_ready", tx_ready, 1);
    step();
    step();
    reset = 1'b0;
    for (int n = 0; n < 60; n++) step();

    // Fill the FIFO, then offer 0x77 while full
    bq = '{rand_byte(), rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    push_seq(bq, 10);
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    step();
    tx_valid = 1'b0;
    chk("rej_count", fifo_count, 4);
    drain(8 * FRAME);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = rand_byte();
      step();
    end
    tx_valid = 1'b0;
    drain(8 * FRAME);

    chk("rx_frames", rx_got.size(), m_sent.size());
    for (int j = 0; j < rx_got.size() && j < m_sent.size(); j++)
      chk("rx_byte", rx_got[j], m_sent[j]);
    for (int j = 0; j < rx_got.size(); j++)
      chk("no_77", (rx_got[j] == 8'h77), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
